// File: rtl/up_pkg.sv
// rtl/up_pkg.sv - shared opcodes, ALU codes, bus sources and FSM encoding for the 4-bit uP sequencer
package up_pkg;

    localparam logic [3:0] OP_JC    = 4'h0;
    localparam logic [3:0] OP_JNC   = 4'h1;
    localparam logic [3:0] OP_CMPI  = 4'h2;
    localparam logic [3:0] OP_CMPM  = 4'h3;
    localparam logic [3:0] OP_LIT   = 4'h4;
    localparam logic [3:0] OP_IN    = 4'h5;
    localparam logic [3:0] OP_LD    = 4'h6;
    localparam logic [3:0] OP_ST    = 4'h7;
    localparam logic [3:0] OP_JZ    = 4'h8;
    localparam logic [3:0] OP_JNZ   = 4'h9;
    localparam logic [3:0] OP_ADDI  = 4'hA;
    localparam logic [3:0] OP_ADDM  = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_OUT   = 4'hD;
    localparam logic [3:0] OP_NANDI = 4'hE;
    localparam logic [3:0] OP_NANDM = 4'hF;

    typedef enum logic [2:0] {
        ALU_NOP  = 3'd0,
        ALU_PASS = 3'd1,
        ALU_CMP  = 3'd2,
        ALU_ADD  = 3'd3,
        ALU_NAND = 3'd4
    } alu_op_t;

    localparam logic [1:0] SRC_OPRND = 2'b00;
    localparam logic [1:0] SRC_RAM   = 2'b01;
    localparam logic [1:0] SRC_PB    = 2'b10;
    localparam logic [1:0] SRC_ACCU  = 2'b11;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FETCH    = 2'd1;
    localparam logic [1:0] ST_EXEC     = 2'd2;
    localparam logic [1:0] ST_MEM_WAIT = 2'd3;

    typedef struct packed {
        logic      pc_inc;
        logic      pc_load;
        logic      acc_load;
        logic      flags_load;
        logic      ram_cs;
        logic      ram_we;
        logic      out_load;
        logic      is_mem;
        alu_op_t   alu_op;
        logic [1:0] src_sel;
    } ctrl_t;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_CMPM) || (op == OP_LD) || (op == OP_ST) ||
               (op == OP_ADDM) || (op == OP_NANDM);
    endfunction

endpackage

// File: rtl/up_ctrl_seq_if.sv
// rtl/up_ctrl_seq_if.sv - control bus between the sequencer and the uP datapath/RAM
interface up_ctrl_seq_if;
    import up_pkg::*;

    logic       run;
    logic       step;
    logic [3:0] instr;
    logic       c_flag;
    logic       z_flag;
    logic       ram_ready;

    logic       phase;
    logic       fetch_en;
    logic       pc_inc;
    logic       pc_load;
    logic       acc_load;
    logic       flags_load;
    alu_op_t    alu_op;
    logic [1:0] src_sel;
    logic       ram_cs;
    logic       ram_we;
    logic       out_load;
    logic       ram_err;
    logic       busy;

    modport master (
        input  run, step, instr, c_flag, z_flag, ram_ready,
        output phase, fetch_en, pc_inc, pc_load, acc_load, flags_load,
               alu_op, src_sel, ram_cs, ram_we, out_load, ram_err, busy
    );

    modport slave (
        output run, step, instr, c_flag, z_flag, ram_ready,
        input  phase, fetch_en, pc_inc, pc_load, acc_load, flags_load,
               alu_op, src_sel, ram_cs, ram_we, out_load, ram_err, busy
    );

endinterface

// File: rtl/up_ctrl_decode.sv
// rtl/up_ctrl_decode.sv - combinational opcode + flags to execute-phase strobe vector
module up_ctrl_decode
    import up_pkg::*;
(
    input  logic [3:0] instr,
    input  logic       c_flag,
    input  logic       z_flag,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl.pc_inc     = 1'b0;
        ctrl.pc_load    = 1'b0;
        ctrl.acc_load   = 1'b0;
        ctrl.flags_load = 1'b0;
        ctrl.ram_cs     = 1'b0;
        ctrl.ram_we     = 1'b0;
        ctrl.out_load   = 1'b0;
        ctrl.is_mem     = is_mem_op(instr);
        ctrl.alu_op     = ALU_NOP;
        ctrl.src_sel    = SRC_OPRND;

        case (instr)
            // conditional branches: a not-taken branch just steps past the operand
            OP_JC: begin
                ctrl.pc_load = c_flag;
                ctrl.pc_inc  = ~c_flag;
            end
            OP_JNC: begin
                ctrl.pc_load = ~c_flag;
                ctrl.pc_inc  = c_flag;
            end
            OP_JZ: begin
                ctrl.pc_load = z_flag;
                ctrl.pc_inc  = ~z_flag;
            end
            OP_JNZ: begin
                ctrl.pc_load = ~z_flag;
                ctrl.pc_inc  = z_flag;
            end
            OP_JMP: ctrl.pc_load = 1'b1;
            OP_CMPI: begin
                ctrl.alu_op     = ALU_CMP;
                ctrl.flags_load = 1'b1;
            end
            OP_LIT: begin
                ctrl.alu_op   = ALU_PASS;
                ctrl.acc_load = 1'b1;
            end
            OP_IN: begin
                ctrl.alu_op   = ALU_PASS;
                ctrl.src_sel  = SRC_PB;
                ctrl.acc_load = 1'b1;
            end
            OP_ADDI: begin
                ctrl.alu_op     = ALU_ADD;
                ctrl.acc_load   = 1'b1;
                ctrl.flags_load = 1'b1;
            end
            OP_NANDI: begin
                ctrl.alu_op     = ALU_NAND;
                ctrl.acc_load   = 1'b1;
                ctrl.flags_load = 1'b1;
            end
            OP_OUT: begin
                ctrl.src_sel  = SRC_ACCU;
                ctrl.out_load = 1'b1;
            end
            OP_CMPM: begin
                ctrl.ram_cs     = 1'b1;
                ctrl.src_sel    = SRC_RAM;
                ctrl.alu_op     = ALU_CMP;
                ctrl.flags_load = 1'b1;
            end
            OP_LD: begin
                ctrl.ram_cs   = 1'b1;
                ctrl.src_sel  = SRC_RAM;
                ctrl.alu_op   = ALU_PASS;
                ctrl.acc_load = 1'b1;
            end
            OP_ST: begin
                ctrl.ram_cs  = 1'b1;
                ctrl.ram_we  = 1'b1;
                ctrl.src_sel = SRC_ACCU;
            end
            OP_ADDM: begin
                ctrl.ram_cs     = 1'b1;
                ctrl.src_sel    = SRC_RAM;
                ctrl.alu_op     = ALU_ADD;
                ctrl.acc_load   = 1'b1;
                ctrl.flags_load = 1'b1;
            end
            OP_NANDM: begin
                ctrl.ram_cs     = 1'b1;
                ctrl.src_sel    = SRC_RAM;
                ctrl.alu_op     = ALU_NAND;
                ctrl.acc_load   = 1'b1;
                ctrl.flags_load = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/up_ctrl_seq.sv
// rtl/up_ctrl_seq.sv - fetch/execute sequencer with RAM wait states, timeout and single-step
module up_ctrl_seq
    import up_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned WAIT_W   = 4
)(
    input  logic          clock,
    input  logic          reset,
    up_ctrl_seq_if.master bus
);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              ram_err_q;
    logic              step_q;
    logic              step_edge;
    logic              timeout;
    logic              mem_ok;
    logic              done;
    ctrl_t             dec;

    up_ctrl_decode u_decode (
        .instr  (bus.instr),
        .c_flag (bus.c_flag),
        .z_flag (bus.z_flag),
        .ctrl   (dec)
    );

    // step_q follows step every cycle, so an edge seen while busy is already stale by IDLE
    assign step_edge = bus.step & ~step_q;
    assign timeout   = (state == ST_MEM_WAIT) && (wait_cnt == WAIT_W'(WAIT_MAX));
    assign mem_ok    = bus.ram_ready & ~timeout;

    always_comb begin
        done = 1'b0;
        case (state)
            ST_EXEC:     done = ~dec.is_mem | bus.ram_ready;
            ST_MEM_WAIT: done = bus.ram_ready | timeout;
            default:     done = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.run || step_edge) state_nxt = ST_FETCH;
            ST_FETCH: state_nxt = ST_EXEC;
            ST_EXEC, ST_MEM_WAIT: begin
                if (done)
                    state_nxt = bus.run ? ST_FETCH : ST_IDLE;
                else
                    state_nxt = ST_MEM_WAIT;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            ram_err_q <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            step_q <= bus.step;
            if (state == ST_MEM_WAIT && !done)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (timeout)
                ram_err_q <= 1'b1;
        end
    end

    // outputs decode straight from state so an async reset clears them in the same cycle
    always_comb begin
        bus.phase      = 1'b0;
        bus.fetch_en   = 1'b0;
        bus.pc_inc     = 1'b0;
        bus.pc_load    = 1'b0;
        bus.acc_load   = 1'b0;
        bus.flags_load = 1'b0;
        bus.alu_op     = ALU_NOP;
        bus.src_sel    = SRC_OPRND;
        bus.ram_cs     = 1'b0;
        bus.ram_we     = 1'b0;
        bus.out_load   = 1'b0;
        case (state)
            ST_FETCH: begin
                bus.fetch_en = 1'b1;
                bus.pc_inc   = 1'b1;
            end
            ST_EXEC, ST_MEM_WAIT: begin
                bus.phase      = 1'b1;
                bus.pc_inc     = dec.pc_inc;
                bus.pc_load    = dec.pc_load;
                bus.alu_op     = dec.alu_op;
                bus.src_sel    = dec.src_sel;
                bus.ram_cs     = dec.ram_cs;
                bus.ram_we     = dec.ram_we;
                bus.out_load   = dec.out_load;
                bus.acc_load   = dec.acc_load & (~dec.is_mem | mem_ok);
                bus.flags_load = dec.flags_load & (~dec.is_mem | mem_ok);
            end
            default: ;
        endcase
    end

    assign bus.ram_err = ram_err_q;
    assign bus.busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_up_ctrl_seq.sv
// tb/tb_up_ctrl_seq.sv - directed self-checking bench for up_ctrl_seq
module tb_up_ctrl_seq;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    up_ctrl_seq_if bus();

    up_ctrl_seq dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {phase, fetch_en, pc_inc, pc_load, acc_load, flags_load, alu_op, src_sel, ram_cs, ram_we, out_load, ram_err, busy}
    logic [15:0] obs;
    assign obs = {bus.phase, bus.fetch_en, bus.pc_inc, bus.pc_load, bus.acc_load, bus.flags_load,
                  3'(bus.alu_op), bus.src_sel, bus.ram_cs, bus.ram_we, bus.out_load, bus.ram_err, bus.busy};

    function automatic logic [15:0] ev(input logic ph, fe, pi, pl, al, fl,
                                       input logic [2:0] alu, input logic [1:0] src,
                                       input logic cs, we, ol, err, bsy);
        return {ph, fe, pi, pl, al, fl, alu, src, cs, we, ol, err, bsy};
    endfunction

    // decode table: strobes packed as {pc_inc, pc_load, acc_load, flags_load, alu[2:0], src[1:0], out_load}
    logic [3:0] t_op  [0:10] = '{4'h0, 4'h0, 4'h1, 4'h8, 4'h9, 4'hC, 4'h2, 4'h5, 4'hA, 4'hE, 4'hD};
    logic       t_c   [0:10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       t_z   [0:10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [9:0] t_stb [0:10] = '{10'b01_00_000_00_0, 10'b10_00_000_00_0, 10'b01_00_000_00_0,
                                 10'b01_00_000_00_0, 10'b10_00_000_00_0, 10'b01_00_000_00_0,
                                 10'b00_01_010_00_0, 10'b00_10_001_10_0, 10'b00_11_011_00_0,
                                 10'b00_11_100_00_0, 10'b00_00_000_11_1};

    task automatic test_reset();
        rst_n = 1'b0;
        bus.run = 1'b1; bus.step = 1'b0; bus.instr = 4'h4;
        bus.c_flag = 1'b0; bus.z_flag = 1'b0; bus.ram_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (obs !== 16'h0) begin
            bad++; $display("FAIL reset_outputs got=%b exp=%b", obs, 16'h0);
        end
    endtask

    task automatic test_lit();
        logic [15:0] exp;
        @(negedge clk); rst_n = 1'b1; #1;
        exp = 16'h0;
        total++;
        if (obs !== exp) begin bad++; $display("FAIL lit_idle got=%b exp=%b", obs, exp); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            exp = ev(0, 1, 1, 0, 0, 0, 3'd0, 2'b00, 0, 0, 0, 0, 1);
            total++;
            if (obs !== exp) begin bad++; $display("FAIL lit_fetch%0d got=%b exp=%b", i, obs, exp); end
            @(negedge clk); #1;
            exp = ev(1, 0, 0, 0, 1, 0, 3'd1, 2'b00, 0, 0, 0, 0, 1);
            total++;
            if (obs !== exp) begin bad++; $display("FAIL lit_exec%0d got=%b exp=%b", i, obs, exp); end
        end
    endtask

    task automatic test_decode();
        logic [15:0] exp;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            bus.instr = t_op[i]; bus.c_flag = t_c[i]; bus.z_flag = t_z[i];
            #1;
            exp = ev(0, 1, 1, 0, 0, 0, 3'd0, 2'b00, 0, 0, 0, 0, 1);
            total++;
            if (obs !== exp) begin bad++; $display("FAIL dec_fetch_op%0h got=%b exp=%b", t_op[i], obs, exp); end
            @(negedge clk); #1;
            exp = {1'b1, 1'b0, t_stb[i][9:6], t_stb[i][5:3], t_stb[i][2:1], 2'b00, t_stb[i][0], 1'b0, 1'b1};
            total++;
            if (obs !== exp) begin bad++; $display("FAIL dec_exec_op%0h_c%0d_z%0d got=%b exp=%b", t_op[i], t_c[i], t_z[i], obs, exp); end
        end
    endtask

    task automatic test_ld_wait();
        logic [15:0] exp;
        @(negedge clk); bus.instr = 4'h6; bus.ram_ready = 1'b0; #1;
        exp = ev(0, 1, 1, 0, 0, 0, 3'd0, 2'b00, 0, 0, 0, 0, 1);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL ld_fetch got=%b exp=%b", obs, exp); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            exp = ev(1, 0, 0, 0, 0, 0, 3'd1, 2'b01, 1, 0, 0, 0, 1);
            total++;
            if (obs !== exp) begin bad++; $display("FAIL ld_wait%0d got=%b exp=%b", i, obs, exp); end
        end
        @(negedge clk); bus.ram_ready = 1'b1; #1;
        exp = ev(1, 0, 0, 0, 1, 0, 3'd1, 2'b01, 1, 0, 0, 0, 1);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL ld_ready got=%b exp=%b", obs, exp); end
    endtask

    task automatic test_st_timeout();
        logic [15:0] exp;
        @(negedge clk); bus.instr = 4'h7; bus.ram_ready = 1'b0; #1;
        exp = ev(0, 1, 1, 0, 0, 0, 3'd0, 2'b00, 0, 0, 0, 0, 1);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL st_fetch got=%b exp=%b", obs, exp); end
        // one EXEC cycle plus WAIT_MAX+1 MEM_WAIT cycles (wait_cnt 0..15) hold the access
        for (int i = 0; i < 17; i++) begin
            @(negedge clk); #1;
            exp = ev(1, 0, 0, 0, 0, 0, 3'd0, 2'b11, 1, 1, 0, 0, 1);
            total++;
            if (obs !== exp) begin bad++; $display("FAIL st_hold%0d got=%b exp=%b", i, obs, exp); end
        end
        @(negedge clk); bus.instr = 4'h4; #1;
        exp = ev(0, 1, 1, 0, 0, 0, 3'd0, 2'b00, 0, 0, 0, 1, 1);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL st_abort_fetch got=%b exp=%b", obs, exp); end
        @(negedge clk); #1;
        exp = ev(1, 0, 0, 0, 1, 0, 3'd1, 2'b00, 0, 0, 0, 1, 1);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL st_err_sticky got=%b exp=%b", obs, exp); end
    endtask

    task automatic test_step();
        logic [15:0] exp_idle;
        logic [15:0] exp_fetch;
        logic [15:0] exp_exec;
        exp_idle  = ev(0, 0, 0, 0, 0, 0, 3'd0, 2'b00, 0, 0, 0, 1, 0);
        exp_fetch = ev(0, 1, 1, 0, 0, 0, 3'd0, 2'b00, 0, 0, 0, 1, 1);
        exp_exec  = ev(1, 0, 0, 0, 1, 0, 3'd1, 2'b00, 0, 0, 0, 1, 1);
        @(negedge clk); #1;
        total++;
        if (obs !== exp_fetch) begin bad++; $display("FAIL step_run_fetch got=%b exp=%b", obs, exp_fetch); end
        @(negedge clk); bus.run = 1'b0; #1;
        total++;
        if (obs !== exp_exec) begin bad++; $display("FAIL step_run_drop_exec got=%b exp=%b", obs, exp_exec); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++;
            if (obs !== exp_idle) begin bad++; $display("FAIL step_idle%0d got=%b exp=%b", i, obs, exp_idle); end
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); bus.step = 1'b1; #1;
            total++;
            if (obs !== exp_idle) begin bad++; $display("FAIL step%0d_edge_idle got=%b exp=%b", k, obs, exp_idle); end
            @(negedge clk); #1;
            total++;
            if (obs !== exp_fetch) begin bad++; $display("FAIL step%0d_fetch got=%b exp=%b", k, obs, exp_fetch); end
            @(negedge clk); #1;
            total++;
            if (obs !== exp_exec) begin bad++; $display("FAIL step%0d_exec got=%b exp=%b", k, obs, exp_exec); end
            for (int i = 0; i < 3; i++) begin
                @(negedge clk); #1;
                total++;
                if (obs !== exp_idle) begin bad++; $display("FAIL step%0d_held_idle%0d got=%b exp=%b", k, i, obs, exp_idle); end
            end
            @(negedge clk); bus.step = 1'b0; #1;
            total++;
            if (obs !== exp_idle) begin bad++; $display("FAIL step%0d_low_idle got=%b exp=%b", k, obs, exp_idle); end
        end
        // edge that rises while busy must be discarded
        @(negedge clk); bus.step = 1'b1; #1;
        @(negedge clk); bus.step = 1'b0; #1;
        total++;
        if (obs !== exp_fetch) begin bad++; $display("FAIL step_busy_fetch got=%b exp=%b", obs, exp_fetch); end
        @(negedge clk); bus.step = 1'b1; #1;
        total++;
        if (obs !== exp_exec) begin bad++; $display("FAIL step_busy_exec got=%b exp=%b", obs, exp_exec); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++;
            if (obs !== exp_idle) begin bad++; $display("FAIL step_busy_discard%0d got=%b exp=%b", i, obs, exp_idle); end
        end
        bus.step = 1'b0;
    endtask

    task automatic test_reset_midwait();
        logic [15:0] exp;
        @(negedge clk); bus.run = 1'b1; bus.instr = 4'h6; bus.ram_ready = 1'b0;
        @(negedge clk); #1;
        exp = ev(0, 1, 1, 0, 0, 0, 3'd0, 2'b00, 0, 0, 0, 1, 1);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL rmw_fetch got=%b exp=%b", obs, exp); end
        @(negedge clk);
        @(negedge clk); #1;
        exp = ev(1, 0, 0, 0, 0, 0, 3'd1, 2'b01, 1, 0, 0, 1, 1);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL rmw_wait got=%b exp=%b", obs, exp); end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (obs !== 16'h0) begin bad++; $display("FAIL rmw_async_clear got=%b exp=%b", obs, 16'h0); end
        @(negedge clk); bus.run = 1'b0; rst_n = 1'b1; #1;
        total++;
        if (obs !== 16'h0) begin bad++; $display("FAIL rmw_after_release got=%b exp=%b", obs, 16'h0); end
        @(negedge clk); #1;
        total++;
        if (obs !== 16'h0) begin bad++; $display("FAIL rmw_stays_idle got=%b exp=%b", obs, 16'h0); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_lit();
        test_decode();
        test_ld_wait();
        test_st_timeout();
        test_step();
        test_reset_midwait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
